// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with any-depth pointer wrap, programmable
// almost-full/almost-empty thresholds, synchronous flush and an optional
// first-word-fall-through read port.
module fifo_param #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AFULL_TH   = 7,
  parameter int unsigned AEMPTY_TH  = 1,
  parameter int unsigned FWFT       = 0,
  localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CW-1:0]         count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_ack_q, overflow_q, underflow_q;
  logic                  wr_accept, rd_accept;

  // Status flags are pure functions of occupancy.
  always_comb begin
    full        = (count_q == CW'(DEPTH));
    empty       = (count_q == '0);
    almostfull  = (count_q >= CW'(AFULL_TH));
    almostempty = (count_q <= CW'(AEMPTY_TH));
    count       = count_q;
    wr_ack      = wr_ack_q;
    overflow    = overflow_q;
    underflow   = underflow_q;
  end

  // Accept decisions and next-state for pointers and occupancy.
  always_comb begin
    // Full/empty are checked on the pre-edge count, so a simultaneous pop
    // never makes room for the write in the same cycle (and vice versa).
    wr_accept = wr_en && !flush && !full;
    rd_accept = rd_en && !flush && !empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (rd_accept) begin
        rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer, occupancy and one-cycle status pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_accept;
      overflow_q  <= wr_en && !flush && full;
      underflow_q <= rd_en && !flush && empty;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head entry shown directly; forced to zero while empty so no X escapes.
    always_comb begin
      data_out = empty ? '0 : mem[rd_ptr_q];
    end
  end else begin : g_std
    logic [DATA_WIDTH-1:0] data_q;

    // Registered read port; holds its value across idle cycles and flush.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
      end else if (rd_accept) begin
        data_q <= mem[rd_ptr_q];
      end
    end

    always_comb begin
      data_out = data_q;
    end
  end

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: two instances (standard DEPTH=8 and FWFT DEPTH=5)
// share one stimulus stream; a queue-based reference model predicts each
// cycle and a monitor process compares the DUT against the predictions.
module tb_fifo_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0;
  logic [15:0] data_in = '0;

  logic [15:0] dout_a, dout_b;
  logic        ack_a, ovf_a, unf_a, full_a, empty_a, af_a, ae_a;
  logic        ack_b, ovf_b, unf_b, full_b, empty_b, af_b, ae_b;
  logic [3:0]  cnt_a;
  logic [2:0]  cnt_b;

  fifo_param #(
    .DATA_WIDTH(16), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(0)
  ) u_std (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
    .data_in(data_in), .data_out(dout_a), .wr_ack(ack_a), .overflow(ovf_a),
    .underflow(unf_a), .full(full_a), .empty(empty_a), .almostfull(af_a),
    .almostempty(ae_a), .count(cnt_a)
  );

  fifo_param #(
    .DATA_WIDTH(16), .DEPTH(5), .AFULL_TH(4), .AEMPTY_TH(1), .FWFT(1)
  ) u_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
    .data_in(data_in), .data_out(dout_b), .wr_ack(ack_b), .overflow(ovf_b),
    .underflow(unf_b), .full(full_b), .empty(empty_b), .almostfull(af_b),
    .almostempty(ae_b), .count(cnt_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cnt_a;
    bit          ack_a, ovf_a, unf_a;
    logic [15:0] dout_a;
    int          cnt_b;
    bit          ack_b, ovf_b, unf_b;
    bit          has_b;
    logic [15:0] head_b;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [15:0] hold_a = '0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and push the model's prediction for it.
  task automatic step(bit w, bit r, bit f, logic [15:0] d);
    exp_t e;
    @(negedge clk);
    wr_en = w; rd_en = r; flush = f; data_in = d;
    e.ack_a = w && !f && (qa.size() < 8);
    e.ovf_a = w && !f && (qa.size() == 8);
    e.unf_a = r && !f && (qa.size() == 0);
    if (f) qa.delete();
    else begin
      if (r && qa.size() > 0) hold_a = qa.pop_front();
      if (e.ack_a) qa.push_back(d);
    end
    e.cnt_a  = qa.size();
    e.dout_a = hold_a;
    e.ack_b = w && !f && (qb.size() < 5);
    e.ovf_b = w && !f && (qb.size() == 5);
    e.unf_b = r && !f && (qb.size() == 0);
    if (f) qb.delete();
    else begin
      if (r && qb.size() > 0) void'(qb.pop_front());
      if (e.ack_b) qb.push_back(d);
    end
    e.cnt_b  = qb.size();
    e.has_b  = qb.size() > 0;
    e.head_b = e.has_b ? qb[0] : 16'h0;
    exp_q.push_back(e);
  endtask

  task automatic check_reset();
    chk("rst_cnt_a", cnt_a, 0);   chk("rst_cnt_b", cnt_b, 0);
    chk("rst_empty_a", empty_a, 1); chk("rst_empty_b", empty_b, 1);
    chk("rst_ae_a", ae_a, 1);     chk("rst_ae_b", ae_b, 1);
    chk("rst_full_a", full_a, 0); chk("rst_af_a", af_a, 0);
    chk("rst_dout_a", dout_a, 0);
    chk("rst_pulses_a", {ack_a, ovf_a, unf_a}, 0);
    chk("rst_pulses_b", {ack_b, ovf_b, unf_b}, 0);
  endtask

  // Monitor: compare DUT outputs against each prediction after its edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cnt_a", cnt_a, e.cnt_a);
        chk("wr_ack_a", ack_a, e.ack_a);
        chk("overflow_a", ovf_a, e.ovf_a);
        chk("underflow_a", unf_a, e.unf_a);
        chk("data_out_a", dout_a, e.dout_a);
        chk("full_a", full_a, e.cnt_a == 8);
        chk("empty_a", empty_a, e.cnt_a == 0);
        chk("almostfull_a", af_a, e.cnt_a >= 6);
        chk("almostempty_a", ae_a, e.cnt_a <= 1);
        chk("cnt_b", cnt_b, e.cnt_b);
        chk("wr_ack_b", ack_b, e.ack_b);
        chk("overflow_b", ovf_b, e.ovf_b);
        chk("underflow_b", unf_b, e.unf_b);
        chk("full_b", full_b, e.cnt_b == 5);
        chk("empty_b", empty_b, e.cnt_b == 0);
        chk("almostfull_b", af_b, e.cnt_b >= 4);
        chk("almostempty_b", ae_b, e.cnt_b <= 1);
        if (e.has_b) chk("data_out_b", dout_b, e.head_b);
      end
    end
  end

  initial begin : driver
    int guard;
    bit wb, rb, fb;
    repeat (2) @(negedge clk);
    check_reset();
    rst_n = 1'b1;

    // Fill past full on both instances.
    for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, 1'b0, 16'(i));
    // Full with both requests: read wins, write overflows.
    step(1'b1, 1'b1, 1'b0, 16'h00AA);
    // Drain past empty.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
    // Empty with both requests: write wins, read underflows.
    step(1'b1, 1'b1, 1'b0, 16'h0BB0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h0C00 + 16'(i));
    // Mid-occupancy both requests: count holds, order preserved.
    step(1'b1, 1'b1, 1'b0, 16'h0D00);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 16'h0);

    // FWFT visibility without rd_en, then flush with a concurrent write.
    step(1'b1, 1'b0, 1'b0, 16'hA5A5);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b1, 16'h1234);
    step(1'b0, 1'b0, 1'b0, 16'h0);

    // Randomised traffic alternating write-heavy and read-heavy phases.
    for (int k = 0; k < 600; k++) begin
      if ((k / 40) % 2 == 0) begin
        wb = ($urandom % 4) != 0;
        rb = ($urandom % 4) == 0;
      end else begin
        wb = ($urandom % 4) == 0;
        rb = ($urandom % 4) != 0;
      end
      fb = ($urandom % 40) == 0;
      step(wb, rb, fb, 16'($urandom));
    end

    // Asynchronous reset mid-stream with five entries held.
    step(1'b0, 1'b0, 1'b1, 16'h0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 16'h5000 + 16'(i));
    step(1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset();
    qa.delete();
    qb.delete();
    hold_a = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 16'hC0DE);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
